pipe_sequencer: RTL and testbench
=================================

# pipe_sequencer

Central pipeline controller for the 24-bit core. It generates the per-stage enable lines for IF/ID/EX/MA/WB and owns the fetch PC. It sequences start, stall, branch redirect and halt/drain. It turns EX-stage results (HLT detection, registered branch_taken/target) and MA memory handshakes into stage enables and flushes, replacing the ad-hoc enable chaining between stages.

## Interface
Parameters:
- RESET_VEC, 24'h000000, PC loaded on reset.
- DRAIN_CYCLES, 2, cycles MA/WB stay enabled after a halt (1..7).

Ports:
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-high.
- run_req  in  1  start pulse; honoured in IDLE or in HALTED once drained.
- halt_in  in  1  valid HLT instruction present in EX.
- branch_taken_in  in  1  registered EX branch decision (instruction now in MA).
- branch_target_in  in  24  redirect address, valid with branch_taken_in.
- hazard_in  in  1  ID load-use hazard; freeze IF/ID, bubble into EX.
- mem_req  in  1  MA stage memory access in progress.
- mem_ack  in  1  memory completion, same-cycle with the last wait cycle.
- pc_out  out  24  fetch PC.
- stage_en  out  5  enables {WB,MA,EX,ID,IF} (bit0 = IF).
- flush_out  out  1  squash IF/ID/EX contents this cycle.
- bubble_out  out  1  ID->EX latch loads NOP this cycle.
- halted_out  out  1  halt fully drained.
- state_out  out  2  IDLE=0, RUN=1, WAIT=2, HALTED=3.
- cycle_cnt  out  24  cycles spent in RUN/WAIT (see Configuration).
- stall_cnt  out  24  cycles with stage_en != 5'h1F while in RUN/WAIT.

## Operation
- Reset: state IDLE, pc_out=RESET_VEC, stage_en=0, flush_out=0, bubble_out=0, halted_out=0, drain counter 0, counters 0.
- IDLE: stage_en=0. run_req -> RUN. pc_out is unchanged.
- RUN: events are evaluated combinationally in priority order:
  1. **mem_req && !mem_ack**: stage_en=0 this cycle; next state WAIT; PC held.
  2. **branch_taken_in**: stage_en=5'h1F, flush_out=1; pc_out <= branch_target_in. A simultaneous halt_in or hazard_in is ignored, because the older branch squashes the HLT.
  3. **halt_in**: stage_en=5'b11000 (MA, WB only); PC held; drain counter <= DRAIN_CYCLES-1; next state HALTED.
  4. **hazard_in**: stage_en=5'b11100, bubble_out=1; PC held.
  5. **Otherwise**: stage_en=5'h1F; pc_out <= pc_out+1.
- WAIT: stage_en=0 while !mem_ack. On mem_ack, RUN rules 2–5 apply this same cycle, then next state RUN. halt_in is deferred until after the ack.
- HALTED: stage_en=5'b11000 while drain counter != 0; the counter decrements each cycle. At 0: stage_en=0 and halted_out=1. run_req with halted_out=1 -> RUN, halted_out <= 0, resuming at held pc_out. run_req while draining is ignored.
- PC arithmetic is 24-bit modulo: 24'hFFFFFF+1 = 24'h000000.
- rst asserted mid-operation: all state returns to reset values immediately. Any outstanding mem transaction is abandoned; mem_ack arriving in IDLE is ignored.

## Timing
- stage_en, flush_out, bubble_out: combinational from state and the current-cycle inputs. Stages sample them at the same clk edge.
- pc_out, state_out, halted_out, counters: registered, and update one edge after the triggering cycle.
- Branch latency: target is visible on pc_out 1 cycle after branch_taken_in.
- Halt: exactly DRAIN_CYCLES cycles with stage_en=5'b11000, counting the halt_in cycle. halted_out rises on the following edge.
- run_req from IDLE: the first enabled cycle is the cycle after the pulse.

## Configuration
- SEQ_PERF_EN defined: cycle_cnt and stall_cnt count as specified. Both are 24-bit, wrap on overflow, and are cleared by rst and on each run_req accepted from IDLE.
- SEQ_PERF_EN undefined: the counter registers are not built; cycle_cnt and stall_cnt are tied to 24'h0. Ports remain present.

## Test plan
- Reset, run_req, 4 idle RUN cycles -> pc_out 0,1,2,3,4; stage_en=5'h1F; state_out=1.
- In RUN at pc=10: branch_taken_in with target 24'h000200 and halt_in in the same cycle -> flush_out=1, next pc_out=24'h000200, state stays RUN.
- hazard_in for 2 cycles at pc=5 -> stage_en=5'b11100, bubble_out=1 both cycles, pc_out stays 5, then increments to 6.
- mem_req with mem_ack 3 cycles later -> stage_en=0 for 3 cycles with state_out=2; the ack cycle gives stage_en=5'h1F and state_out=1 next. With SEQ_PERF_EN, stall_cnt=3.
- halt_in at DRAIN_CYCLES=2 -> stage_en=5'b11000 for 2 cycles, then 0 with halted_out=1. run_req -> RUN at the held pc.
- pc at 24'hFFFFFF, one RUN cycle -> pc_out=24'h000000. Assert rst mid-WAIT -> state_out=0, pc_out=RESET_VEC, stage_en=0.

Source files
------------

// File: rtl/pipe_sequencer.sv
// Pipeline controller: per-stage enables, fetch PC, start/stall/branch/halt-drain sequencing.
// Optional performance counters are built when SEQ_PERF_EN is defined.
module pipe_sequencer #(
  parameter logic [23:0] RESET_VEC    = 24'h000000,
  parameter int          DRAIN_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        run_req,
  input  logic        halt_in,
  input  logic        branch_taken_in,
  input  logic [23:0] branch_target_in,
  input  logic        hazard_in,
  input  logic        mem_req,
  input  logic        mem_ack,
  output logic [23:0] pc_out,
  output logic [4:0]  stage_en,
  output logic        flush_out,
  output logic        bubble_out,
  output logic        halted_out,
  output logic [1:0]  state_out,
  output logic [23:0] cycle_cnt,
  output logic [23:0] stall_cnt
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    WAIT   = 2'd2,
    HALTED = 2'd3
  } state_t;

  localparam logic [2:0] DRAIN_LOAD = 3'(DRAIN_CYCLES - 1);
  localparam logic [4:0] EN_ALL     = 5'h1F;
  localparam logic [4:0] EN_DRAIN   = 5'b11000;
  localparam logic [4:0] EN_HAZARD  = 5'b11100;

  state_t      state_reg, state_next;
  logic [23:0] pc_reg, pc_next;
  logic [2:0]  drain_reg, drain_next;
  logic        halted_reg, halted_next;
  logic        mem_blocked;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg  <= IDLE;
      pc_reg     <= RESET_VEC;
      drain_reg  <= 3'd0;
      halted_reg <= 1'b0;
    end else begin
      state_reg  <= state_next;
      pc_reg     <= pc_next;
      drain_reg  <= drain_next;
      halted_reg <= halted_next;
    end
  end

  // In WAIT only the ack matters; in RUN a fresh request without ack stalls.
  assign mem_blocked = (state_reg == WAIT) ? !mem_ack : (mem_req && !mem_ack);

  always_comb begin
    state_next  = state_reg;
    pc_next     = pc_reg;
    drain_next  = drain_reg;
    halted_next = halted_reg;
    stage_en    = 5'h00;
    flush_out   = 1'b0;
    bubble_out  = 1'b0;
    case (state_reg)
      IDLE: begin
        if (run_req) state_next = RUN;
      end
      RUN, WAIT: begin
        if (mem_blocked) begin
          state_next = WAIT;
        end else begin
          state_next = RUN;
          if (branch_taken_in) begin
            // The branch is older than anything in EX, so it overrides halt and hazard.
            stage_en  = EN_ALL;
            flush_out = 1'b1;
            pc_next   = branch_target_in;
          end else if (halt_in) begin
            stage_en    = EN_DRAIN;
            drain_next  = DRAIN_LOAD;
            halted_next = (DRAIN_LOAD == 3'd0);
            state_next  = HALTED;
          end else if (hazard_in) begin
            stage_en   = EN_HAZARD;
            bubble_out = 1'b1;
          end else begin
            stage_en = EN_ALL;
            pc_next  = pc_reg + 24'd1;
          end
        end
      end
      HALTED: begin
        if (drain_reg != 3'd0) begin
          stage_en    = EN_DRAIN;
          drain_next  = drain_reg - 3'd1;
          halted_next = (drain_reg == 3'd1);
        end else if (halted_reg && run_req) begin
          state_next  = RUN;
          halted_next = 1'b0;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign pc_out     = pc_reg;
  assign state_out  = state_reg;
  assign halted_out = halted_reg;

`ifdef SEQ_PERF_EN
  logic [23:0] cycle_cnt_reg, stall_cnt_reg;
  logic        active;

  assign active = (state_reg == RUN) || (state_reg == WAIT);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cycle_cnt_reg <= 24'd0;
      stall_cnt_reg <= 24'd0;
    end else if (state_reg == IDLE && run_req) begin
      cycle_cnt_reg <= 24'd0;
      stall_cnt_reg <= 24'd0;
    end else if (active) begin
      cycle_cnt_reg <= cycle_cnt_reg + 24'd1;
      if (stage_en != EN_ALL) stall_cnt_reg <= stall_cnt_reg + 24'd1;
    end
  end

  assign cycle_cnt = cycle_cnt_reg;
  assign stall_cnt = stall_cnt_reg;
`else
  assign cycle_cnt = 24'h0;
  assign stall_cnt = 24'h0;
`endif

endmodule

// File: tb/tb_pipe_sequencer.sv
// Self-checking bench for pipe_sequencer: directed test-plan steps, then random stimulus vs a cycle model.
module tb_pipe_sequencer;
  localparam logic [23:0] RVEC  = 24'h000000;
  localparam int          DRAIN = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        run_req, halt_in, branch_taken_in, hazard_in, mem_req, mem_ack;
  logic [23:0] branch_target_in;
  logic [23:0] pc_out, cycle_cnt, stall_cnt;
  logic [4:0]  stage_en;
  logic        flush_out, bubble_out, halted_out;
  logic [1:0]  state_out;

  int errors = 0;
  int checks = 0;

  // Model: mode uses the external state_out numbering; m_since counts cycles since the halt.
  int          m_mode;
  int          m_since;
  logic [23:0] m_pc, m_cyc, m_stall;

  pipe_sequencer #(.RESET_VEC(RVEC), .DRAIN_CYCLES(DRAIN)) dut (
    .clk(clk), .rst(rst), .run_req(run_req), .halt_in(halt_in),
    .branch_taken_in(branch_taken_in), .branch_target_in(branch_target_in),
    .hazard_in(hazard_in), .mem_req(mem_req), .mem_ack(mem_ack),
    .pc_out(pc_out), .stage_en(stage_en), .flush_out(flush_out),
    .bubble_out(bubble_out), .halted_out(halted_out), .state_out(state_out),
    .cycle_cnt(cycle_cnt), .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [23:0] got, input logic [23:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic clear_inputs();
    run_req = 0; halt_in = 0; branch_taken_in = 0; branch_target_in = 24'h0;
    hazard_in = 0; mem_req = 0; mem_ack = 0;
  endtask

  task automatic check_reset();
    m_mode = 0; m_since = 0; m_pc = RVEC; m_cyc = 24'h0; m_stall = 24'h0;
    chk("rst_state", 24'(state_out), 24'd0);
    chk("rst_pc", pc_out, RVEC);
    chk("rst_en", 24'(stage_en), 24'd0);
    chk("rst_flush", 24'(flush_out), 24'd0);
    chk("rst_bubble", 24'(bubble_out), 24'd0);
    chk("rst_halted", 24'(halted_out), 24'd0);
    chk("rst_cycle_cnt", cycle_cnt, 24'd0);
    chk("rst_stall_cnt", stall_cnt, 24'd0);
  endtask

  // Assert rst asynchronously between clock edges, check, then release.
  task automatic reset_mid();
    @(negedge clk);
    clear_inputs();
    rst = 1;
    #1;
    check_reset();
    @(negedge clk);
    rst = 0;
  endtask

  // One clock cycle: drive inputs, check outputs against the model, advance the model.
  task automatic cycle(input logic run, input logic halt, input logic br, input logic [23:0] tgt,
                       input logic haz, input logic mreq, input logic mack);
    logic [4:0]  e_en;
    logic        e_fl, e_bu;
    int          n_mode, n_since;
    logic [23:0] n_pc;
    @(negedge clk);
    run_req = run; halt_in = halt; branch_taken_in = br; branch_target_in = tgt;
    hazard_in = haz; mem_req = mreq; mem_ack = mack;
    #1;
    e_en = 5'h00; e_fl = 0; e_bu = 0;
    n_mode = m_mode; n_since = m_since; n_pc = m_pc;
    case (m_mode)
      0: if (run) n_mode = 1;
      1, 2: begin
        if ((m_mode == 1 && mreq && !mack) || (m_mode == 2 && !mack)) begin
          n_mode = 2;
        end else begin
          n_mode = 1;
          if (br) begin
            e_en = 5'h1F; e_fl = 1; n_pc = tgt;
          end else if (halt) begin
            e_en = 5'b11000; n_mode = 3; n_since = 1;
          end else if (haz) begin
            e_en = 5'b11100; e_bu = 1;
          end else begin
            e_en = 5'h1F; n_pc = m_pc + 24'd1;
          end
        end
      end
      default: begin
        if (m_since < DRAIN) begin
          e_en = 5'b11000; n_since = m_since + 1;
        end else if (run) begin
          n_mode = 1;
        end
      end
    endcase
    chk("state_out", 24'(state_out), 24'(m_mode));
    chk("pc_out", pc_out, m_pc);
    chk("halted_out", 24'(halted_out), 24'((m_mode == 3 && m_since >= DRAIN) ? 1 : 0));
    chk("stage_en", 24'(stage_en), 24'(e_en));
    chk("flush_out", 24'(flush_out), 24'(e_fl));
    chk("bubble_out", 24'(bubble_out), 24'(e_bu));
`ifdef SEQ_PERF_EN
    chk("cycle_cnt", cycle_cnt, m_cyc);
    chk("stall_cnt", stall_cnt, m_stall);
`else
    chk("cycle_cnt", cycle_cnt, 24'd0);
    chk("stall_cnt", stall_cnt, 24'd0);
`endif
    if (m_mode == 0 && run) begin
      m_cyc = 24'd0; m_stall = 24'd0;
    end else if (m_mode == 1 || m_mode == 2) begin
      m_cyc = m_cyc + 24'd1;
      if (e_en != 5'h1F) m_stall = m_stall + 24'd1;
    end
    m_mode = n_mode; m_since = n_since; m_pc = n_pc;
  endtask

  task automatic plain(input int n);
    for (int i = 0; i < n; i++) cycle(0, 0, 0, 24'h0, 0, 0, 0);
  endtask

  // Check pc_out just after the edge that closes the previous cycle.
  task automatic tp(input string tag, input logic [23:0] exp);
    @(posedge clk);
    #1;
    chk(tag, pc_out, exp);
  endtask

  initial begin
    clear_inputs();
    rst = 1;
    #2;
    check_reset();
    @(negedge clk);
    rst = 0;

    // Start and free-running fetch
    cycle(1, 0, 0, 24'h0, 0, 0, 0);
    plain(4);
    tp("tp_pc_after_4_run", 24'd4);
    plain(6);
    tp("tp_pc_10", 24'd10);
    // Branch with simultaneous halt: branch wins
    cycle(0, 1, 1, 24'h000200, 0, 0, 0);
    tp("tp_branch_target", 24'h000200);
    // Hazard for two cycles at pc=5
    cycle(0, 0, 1, 24'd5, 0, 0, 0);
    cycle(0, 0, 0, 24'h0, 1, 0, 0);
    cycle(0, 0, 0, 24'h0, 1, 0, 0);
    tp("tp_hazard_hold", 24'd5);
    plain(1);
    tp("tp_hazard_resume", 24'd6);
    // Memory wait: ack three cycles after the request
    cycle(0, 0, 0, 24'h0, 0, 1, 0);
    cycle(0, 0, 0, 24'h0, 0, 1, 0);
    cycle(0, 0, 0, 24'h0, 0, 1, 0);
    cycle(0, 0, 0, 24'h0, 0, 1, 1);
    plain(1);
    // Halt, drain, restart
    cycle(0, 1, 0, 24'h0, 0, 0, 0);
    plain(3);
    cycle(1, 0, 0, 24'h0, 0, 0, 0);
    plain(1);
    // PC wrap
    cycle(0, 0, 1, 24'hFFFFFF, 0, 0, 0);
    cycle(0, 0, 0, 24'h0, 0, 0, 0);
    tp("tp_pc_wrap", 24'h000000);
    // Reset while waiting on memory
    cycle(0, 0, 0, 24'h0, 0, 1, 0);
    cycle(0, 0, 0, 24'h0, 0, 1, 0);
    reset_mid();
    cycle(0, 0, 0, 24'h0, 0, 0, 1);

    // Random phase
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(199) == 0) begin
        reset_mid();
      end else begin
        cycle($urandom_range(99) < 20, $urandom_range(99) < 8, $urandom_range(99) < 10,
              24'($urandom), $urandom_range(99) < 15, $urandom_range(99) < 20,
              $urandom_range(99) < 40);
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
